// File: rtl/cpu_write_bridge.sv
// cpu_write_bridge: captures 6502 writes to $8000-$FFFF and replays them
// as SDRAM write requests through a 4-entry FIFO.
module cpu_write_bridge #(
   parameter int unsigned SAMPLE_DELAY = 10,
   parameter logic [22:0] BASE_ADDR    = 23'h000000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        enable,
   input  logic        c6502_m2,
   input  logic        c6502_rw,
   input  logic        c6502_cs,
   input  logic [14:0] c6502_addr,
   input  logic [7:0]  c6502_data,
   output logic [22:0] ram_addr,
   output logic        ram_rw,
   output logic [31:0] data_in,
   input  logic        busy,
   output logic        in_valid,
   output logic [7:0]  bank_reg,
   output logic        overflow,
   output logic [15:0] write_count
);

   localparam int CW = (SAMPLE_DELAY > 2) ? $clog2(SAMPLE_DELAY) : 1;

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_WAIT = 2'd1;
   localparam logic [1:0] S_HOLD = 2'd2;

   localparam logic [1:0] D_IDLE = 2'd0;
   localparam logic [1:0] D_REQ  = 2'd1;
   localparam logic [1:0] D_GAP  = 2'd2;

   logic m2_s1_q, m2_s_q, m2_d_q;
   logic m2_rise;

   logic [1:0]    s_state_q, s_state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [7:0]    bank_q, bank_d;
   logic          push;

   logic [22:0] mem_q [4];
   logic [22:0] mem_d [4];
   logic [2:0]  wr_ptr_q, wr_ptr_d;
   logic [2:0]  rd_ptr_q, rd_ptr_d;
   logic        full, empty, push_ok, pop;
   logic [22:0] head;
   logic [15:0] wcnt_q, wcnt_d;
   logic        ovf_q, ovf_d;

   logic [1:0]  d_state_q, d_state_d;
   logic        in_valid_q, in_valid_d;
   logic [22:0] ram_addr_q, ram_addr_d;
   logic [31:0] data_in_q, data_in_d;

   assign m2_rise = m2_s_q & ~m2_d_q;

   always_comb begin
      s_state_d = s_state_q;
      cnt_d     = cnt_q;
      bank_d    = bank_q;
      push      = 1'b0;
      case (s_state_q)
         S_IDLE: begin
            if (m2_rise && enable) begin
               cnt_d     = CW'(SAMPLE_DELAY - 1);
               s_state_d = S_WAIT;
            end
         end
         S_WAIT: begin
            if (cnt_q == '0) begin
               if (!c6502_rw && !c6502_cs) begin
                  push   = 1'b1;
                  bank_d = c6502_data;
               end
               s_state_d = S_HOLD;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         S_HOLD: begin
            if (!m2_s_q) s_state_d = S_IDLE;
         end
         default: s_state_d = S_IDLE;
      endcase
      // losing enable aborts any sample in progress
      if (!enable) begin
         s_state_d = S_IDLE;
         push      = 1'b0;
         bank_d    = bank_q;
      end
   end

   assign full  = (wr_ptr_q[1:0] == rd_ptr_q[1:0]) &&
                  (wr_ptr_q[2] != rd_ptr_q[2]);
   assign empty = (wr_ptr_q == rd_ptr_q);
   assign head  = mem_q[rd_ptr_q[1:0]];

   // a pop in the same cycle frees the slot for a push into a full FIFO
   assign push_ok = push && (!full || pop);

   always_comb begin
      mem_d = mem_q;
      if (push_ok) mem_d[wr_ptr_q[1:0]] = {c6502_addr, c6502_data};
      wr_ptr_d = wr_ptr_q + {2'b00, push_ok};
      rd_ptr_d = rd_ptr_q + {2'b00, pop};
      wcnt_d   = wcnt_q + {15'h0, push_ok};
      ovf_d    = ovf_q | (push & ~push_ok);
   end

   always_comb begin
      d_state_d  = d_state_q;
      in_valid_d = in_valid_q;
      ram_addr_d = ram_addr_q;
      data_in_d  = data_in_q;
      pop        = 1'b0;
      case (d_state_q)
         D_IDLE: begin
            if (!empty && enable && !busy) begin
               ram_addr_d = BASE_ADDR + {8'h00, head[22:8]};
               data_in_d  = {24'h0, head[7:0]};
               in_valid_d = 1'b1;
               d_state_d  = D_REQ;
            end
         end
         D_REQ: begin
            if (!busy) begin
               pop        = 1'b1;
               in_valid_d = 1'b0;
               d_state_d  = D_GAP;
            end
         end
         D_GAP:   d_state_d = D_IDLE;
         default: d_state_d = D_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         m2_s1_q    <= 1'b0;
         m2_s_q     <= 1'b0;
         m2_d_q     <= 1'b0;
         s_state_q  <= S_IDLE;
         cnt_q      <= '0;
         bank_q     <= 8'h00;
         for (int i = 0; i < 4; i++) mem_q[i] <= '0;
         wr_ptr_q   <= 3'd0;
         rd_ptr_q   <= 3'd0;
         wcnt_q     <= 16'h0;
         ovf_q      <= 1'b0;
         d_state_q  <= D_IDLE;
         in_valid_q <= 1'b0;
         ram_addr_q <= 23'h0;
         data_in_q  <= 32'h0;
      end else begin
         m2_s1_q    <= c6502_m2;
         m2_s_q     <= m2_s1_q;
         m2_d_q     <= m2_s_q;
         s_state_q  <= s_state_d;
         cnt_q      <= cnt_d;
         bank_q     <= bank_d;
         mem_q      <= mem_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         wcnt_q     <= wcnt_d;
         ovf_q      <= ovf_d;
         d_state_q  <= d_state_d;
         in_valid_q <= in_valid_d;
         ram_addr_q <= ram_addr_d;
         data_in_q  <= data_in_d;
      end
   end

   assign ram_addr    = ram_addr_q;
   assign ram_rw      = 1'b1;
   assign data_in     = data_in_q;
   assign in_valid    = in_valid_q;
   assign bank_reg    = bank_q;
   assign overflow    = ovf_q;
   assign write_count = wcnt_q;

endmodule

// File: tb/tb_cpu_write_bridge.sv
// Bench for cpu_write_bridge: directed and randomized CPU cycles checked
// against a queue-based model of accepted writes.
module tb_cpu_write_bridge;

   logic        clk = 1'b0;
   logic        rst, enable, m2, rw, cs;
   logic [14:0] addr;
   logic [7:0]  data;
   logic        busy_cmd, rbusy, rand_mode;
   logic        busy;

   logic [22:0] ram_addr0, ram_addr1;
   logic        ram_rw0, ram_rw1, in_valid0, in_valid1;
   logic [31:0] data_in0, data_in1;
   logic [7:0]  bank0, bank1;
   logic        ovf0, ovf1;
   logic [15:0] wc0, wc1;

   always #10 clk = ~clk;

   assign busy = rand_mode ? rbusy : busy_cmd;

   always @(negedge clk) rbusy <= ($urandom_range(0, 1) == 1);

   cpu_write_bridge #(.SAMPLE_DELAY(10), .BASE_ADDR(23'h000000)) u0 (
      .clk(clk), .rst(rst), .enable(enable), .c6502_m2(m2),
      .c6502_rw(rw), .c6502_cs(cs), .c6502_addr(addr),
      .c6502_data(data), .ram_addr(ram_addr0), .ram_rw(ram_rw0),
      .data_in(data_in0), .busy(busy), .in_valid(in_valid0),
      .bank_reg(bank0), .overflow(ovf0), .write_count(wc0));

   cpu_write_bridge #(.SAMPLE_DELAY(10), .BASE_ADDR(23'h7FFFF0)) u1 (
      .clk(clk), .rst(rst), .enable(enable), .c6502_m2(m2),
      .c6502_rw(rw), .c6502_cs(cs), .c6502_addr(addr),
      .c6502_data(data), .ram_addr(ram_addr1), .ram_rw(ram_rw1),
      .data_in(data_in1), .busy(busy), .in_valid(in_valid1),
      .bank_reg(bank1), .overflow(ovf1), .write_count(wc1));

   // request monitor
   int          acc0 = 0, acc1 = 0;
   int          stab_err = 0, gap_err = 0, rw_err = 0;
   logic [22:0] obs_a [$];
   logic [31:0] obs_d [$];
   logic [22:0] last1 = '0;
   logic        prev_v = 1'b0, prev_acc = 1'b0;
   logic [22:0] prev_a = '0;
   logic [31:0] prev_d = '0;

   always @(posedge clk) begin
      if (rst) begin
         prev_v   <= 1'b0;
         prev_acc <= 1'b0;
      end else begin
         if (in_valid0) begin
            if (ram_rw0 !== 1'b1) rw_err <= rw_err + 1;
            if (prev_v && !prev_acc &&
                (ram_addr0 !== prev_a || data_in0 !== prev_d))
               stab_err <= stab_err + 1;
            if (prev_acc) gap_err <= gap_err + 1;
         end
         prev_acc <= in_valid0 && !busy;
         prev_v   <= in_valid0;
         prev_a   <= ram_addr0;
         prev_d   <= data_in0;
         if (in_valid0 && !busy) begin
            acc0 <= acc0 + 1;
            obs_a.push_back(ram_addr0);
            obs_d.push_back(data_in0);
         end
         if (in_valid1 && !busy) begin
            acc1  <= acc1 + 1;
            last1 <= ram_addr1;
         end
      end
   end

   int total = 0, passed = 0, failed = 0;

   // reference model: pending writes the bridge should replay, in order
   logic [14:0] exp_a [$];
   logic [7:0]  exp_d [$];
   int          m_pushed, acc_base, obs_base;
   logic [15:0] m_wc;
   logic [7:0]  m_bank;
   logic        m_ovf;

   function automatic logic [22:0] addr_of(input int base, input logic [14:0] a);
      return 23'((base + int'(a)) % (1 << 23));
   endfunction

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      total++;
      assert (got === exp) passed++;
      else begin
         failed++;
         $error("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(negedge clk);
      #1;
   endtask

   task automatic model_reset();
      exp_a.delete();
      exp_d.delete();
      m_pushed = 0;
      m_wc     = 16'h0;
      m_bank   = 8'h00;
      m_ovf    = 1'b0;
      acc_base = acc0;
      obs_base = obs_a.size();
   endtask

   task automatic do_reset();
      rst = 1'b1;
      step();
      step();
      rst = 1'b0;
      model_reset();
   endtask

   task automatic cpu_cycle(input logic r, input logic c, input logic [14:0] a,
                            input logic [7:0] d, input int hi);
      rw   = r;
      cs   = c;
      addr = a;
      data = d;
      m2   = 1'b1;
      repeat (hi) step();
      m2 = 1'b0;
      repeat (12) step();
      if (enable && !r && !c) begin
         m_bank = d;
         if (m_pushed - (acc0 - acc_base) < 4) begin
            exp_a.push_back(a);
            exp_d.push_back(d);
            m_pushed++;
            m_wc++;
         end else begin
            m_ovf = 1'b1;
         end
      end
      rw = 1'b1;
      cs = 1'b1;
   endtask

   task automatic wait_acc(input int n);
      int k;
      k = 0;
      while ((acc0 - acc_base) < n && k < 300) begin
         step();
         k++;
      end
      if (k >= 300) check("accept_timeout", 32'(acc0 - acc_base), 32'(n));
   endtask

   task automatic compare_all(input string tag);
      check({tag, "_len"}, 32'(obs_a.size() - obs_base), 32'(exp_a.size()));
      foreach (exp_a[i]) begin
         if (obs_base + i < obs_a.size()) begin
            check({tag, "_addr"}, 32'(obs_a[obs_base + i]),
                  32'(addr_of(0, exp_a[i])));
            check({tag, "_data"}, obs_d[obs_base + i], {24'h0, exp_d[i]});
         end
      end
   endtask

   initial begin
      logic [22:0] a_hold;
      logic [31:0] d_hold;
      int          snap, snap1, k;

      rst       = 1'b1;
      enable    = 1'b1;
      m2        = 1'b0;
      rw        = 1'b1;
      cs        = 1'b1;
      addr      = '0;
      data      = '0;
      busy_cmd  = 1'b0;
      rand_mode = 1'b0;
      model_reset();
      repeat (3) step();

      check("rst_in_valid", 32'(in_valid0), 32'd0);
      check("rst_ram_rw", 32'(ram_rw0), 32'd1);
      check("rst_ram_addr", 32'(ram_addr0), 32'h0);
      check("rst_data_in", data_in0, 32'h0);
      check("rst_bank", 32'(bank0), 32'h0);
      check("rst_overflow", 32'(ovf0), 32'd0);
      check("rst_wcount", 32'(wc0), 32'd0);
      rst = 1'b0;
      model_reset();

      // single write
      cpu_cycle(1'b0, 1'b0, 15'h0123, 8'h5A, 16);
      wait_acc(1);
      repeat (5) step();
      check("single_acc", 32'(acc0 - acc_base), 32'd1);
      check("single_addr", 32'(obs_a[obs_base]), 32'h000123);
      check("single_data", obs_d[obs_base], 32'h0000005A);
      check("single_bank", 32'(bank0), 32'h5A);
      check("single_wc", 32'(wc0), 32'd1);

      // cycles that must not push
      snap = acc0;
      cpu_cycle(1'b1, 1'b0, 15'h0200, 8'h11, 16);
      cpu_cycle(1'b0, 1'b1, 15'h0201, 8'h22, 16);
      enable = 1'b0;
      cpu_cycle(1'b0, 1'b0, 15'h0202, 8'h33, 16);
      enable = 1'b1;
      repeat (10) step();
      check("nowrite_acc", 32'(acc0 - snap), 32'd0);
      check("nowrite_wc", 32'(wc0), 32'(m_wc));
      check("nowrite_bank", 32'(bank0), 32'(m_bank));

      // handshake with busy 1,1,0 while in_valid is high
      busy_cmd = 1'b1;
      cpu_cycle(1'b0, 1'b0, 15'h0456, 8'hC3, 16);
      busy_cmd = 1'b0;
      k = 0;
      while (!in_valid0 && k < 20) begin
         step();
         k++;
      end
      busy_cmd = 1'b1;
      check("hs_valid_up", 32'(in_valid0), 32'd1);
      a_hold = ram_addr0;
      d_hold = data_in0;
      snap   = acc0;
      check("hs_addr", 32'(a_hold), 32'h000456);
      check("hs_data", d_hold, 32'h000000C3);
      step();
      check("hs_hold1_valid", 32'(in_valid0), 32'd1);
      check("hs_hold1_addr", 32'(ram_addr0), 32'(a_hold));
      step();
      check("hs_hold2_valid", 32'(in_valid0), 32'd1);
      check("hs_hold2_data", data_in0, d_hold);
      busy_cmd = 1'b0;
      step();
      check("hs_gap_valid", 32'(in_valid0), 32'd0);
      check("hs_one_accept", 32'(acc0 - snap), 32'd1);
      repeat (6) step();
      check("hs_no_reissue", 32'(acc0 - snap), 32'd1);

      // randomized CPU traffic with random busy
      rand_mode = 1'b1;
      for (int i = 0; i < 20; i++) begin
         cpu_cycle(($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0),
                   15'($urandom), 8'($urandom), 16);
      end
      rand_mode = 1'b0;
      busy_cmd  = 1'b0;
      wait_acc(m_pushed);
      repeat (5) step();
      compare_all("rand");
      check("rand_wc", 32'(wc0), 32'(m_wc));
      check("rand_bank", 32'(bank0), 32'(m_bank));
      check("rand_ovf", 32'(ovf0), 32'(m_ovf));

      // backpressure: FIFO fills, two writes dropped
      do_reset();
      busy_cmd = 1'b1;
      for (int i = 0; i < 6; i++)
         cpu_cycle(1'b0, 1'b0, 15'(i), 8'(i + 1), 16);
      repeat (400 - 6 * 28) step();
      check("bp_no_issue", 32'(acc0 - acc_base), 32'd0);
      check("bp_model_ovf", 32'(ovf0), 32'(m_ovf));
      busy_cmd = 1'b0;
      wait_acc(4);
      repeat (10) step();
      compare_all("bp");
      check("bp_acc", 32'(acc0 - acc_base), 32'd4);
      check("bp_ovf", 32'(ovf0), 32'd1);
      check("bp_wc", 32'(wc0), 32'd4);
      check("bp_bank", 32'(bank0), 32'h06);

      // long M2 high pulse and address wrap
      snap  = acc0;
      snap1 = acc1;
      cpu_cycle(1'b0, 1'b0, 15'h0020, 8'h77, 60);
      repeat (10) step();
      check("glitch_acc0", 32'(acc0 - snap), 32'd1);
      check("glitch_acc1", 32'(acc1 - snap1), 32'd1);
      check("wrap_addr", 32'(last1), 32'(addr_of(23'h7FFFF0, 15'h0020)));
      check("base0_addr", 32'(obs_a[obs_a.size() - 1]), 32'h000020);

      // reset while a request is pending with 3 entries queued
      busy_cmd = 1'b1;
      for (int i = 0; i < 3; i++)
         cpu_cycle(1'b0, 1'b0, 15'h0300 + 15'(i), 8'hA0 + 8'(i), 16);
      busy_cmd = 1'b0;
      k = 0;
      while (!in_valid0 && k < 20) begin
         step();
         k++;
      end
      busy_cmd = 1'b1;
      step();
      check("mid_in_req", 32'(in_valid0), 32'd1);
      snap = acc0;
      rst  = 1'b1;
      step();
      check("mid_rst_valid", 32'(in_valid0), 32'd0);
      check("mid_rst_wc", 32'(wc0), 32'd0);
      check("mid_rst_ovf", 32'(ovf0), 32'd0);
      check("mid_rst_bank", 32'(bank0), 32'd0);
      rst      = 1'b0;
      busy_cmd = 1'b0;
      repeat (50) step();
      check("mid_no_issue", 32'(acc0 - snap), 32'd0);
      check("mid_valid_low", 32'(in_valid0), 32'd0);

      check("stability", 32'(stab_err), 32'd0);
      check("gap_after_accept", 32'(gap_err), 32'd0);
      check("ram_rw_high", 32'(rw_err), 32'd0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
